// File: rtl/input_cond_pkg.sv
// Shared types and defaults for the button input conditioner.
// Optional autorepeat is enabled with INPUT_COND_AUTOREPEAT_EN.
package input_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } btn_state_t;

  localparam int DEF_NUM_CH       = 8;
  localparam int DEF_TICK_DIV     = 25200;
  localparam int DEF_DB_TICKS     = 5;
  localparam int DEF_REPEAT_DELAY = 400;
  localparam int DEF_REPEAT_RATE  = 100;

  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  function automatic int max2(input int a,
                              input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// Per-channel debounce FSM with registered edge pulses.
// Autorepeat logic is built only with INPUT_COND_AUTOREPEAT_EN.
module input_cond_ch
  import input_cond_pkg::*;
#(
  parameter int DB_TICKS     = DEF_DB_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk_p,
  input  logic resetn,
  input  logic sync,
  input  logic tick,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int DW = cnt_w(DB_TICKS);

  btn_state_t    state;
  logic [DW-1:0] db_cnt;
  logic          db_done;

  assign db_done = tick &&
    (db_cnt == DW'(DB_TICKS - 1));

  always_ff @(posedge clk_p) begin
    if (!resetn) begin
      state  <= RELEASED;
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (sync) begin
            state  <= PRESS_PEND;
            db_cnt <= '0;
          end
        end
        PRESS_PEND: begin
          if (!sync) begin
            state <= RELEASED;
          end else if (db_done) begin
            state <= PRESSED;
            level <= 1'b1;
            press <= 1'b1;
          end else if (tick) begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state  <= RELEASE_PEND;
            db_cnt <= '0;
          end
        end
        RELEASE_PEND: begin
          if (sync) begin
            state <= PRESSED;
          end else if (db_done) begin
            state <= RELEASED;
            level <= 1'b0;
            rel   <= 1'b1;
          end else if (tick) begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int RW =
    cnt_w(max2(REPEAT_DELAY, REPEAT_RATE));

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_lim;
  logic          rep_run;
  logic          held;
  logic          entering;
  logic          leaving;

  assign held = (state == PRESSED) ||
                (state == RELEASE_PEND);
  assign entering = (state == PRESS_PEND) &&
                    sync && db_done;
  assign leaving = (state == RELEASE_PEND) &&
                   !sync && db_done;
  assign rep_lim = rep_run ?
    RW'(REPEAT_RATE - 1) :
    RW'(REPEAT_DELAY - 1);

  // First interval uses the delay, later ones the rate
  always_ff @(posedge clk_p) begin
    if (!resetn) begin
      rep_cnt <= '0;
      rep_run <= 1'b0;
      rpt     <= 1'b0;
    end else begin
      rpt <= 1'b0;
      if (entering) begin
        rep_cnt <= '0;
        rep_run <= 1'b0;
      end else if (held && tick && !leaving) begin
        if (rep_cnt == rep_lim) begin
          rpt     <= 1'b1;
          rep_cnt <= '0;
          rep_run <= 1'b1;
        end else if (rep_cnt != '1) begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Button synchronisers, shared ms timebase and per-channel conditioners.
// Define INPUT_COND_AUTOREPEAT_EN to build the autorepeat outputs.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int DB_TICKS     = DEF_DB_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic              clk_p,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] raw_btn,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_repeat,
  output logic              any_press,
  output logic              tick
);

  localparam int TW = cnt_w(TICK_DIV - 1);

  logic [NUM_CH-1:0] meta;
  logic [NUM_CH-1:0] sync;
  logic [TW-1:0]     tick_cnt;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_p) begin
    if (!resetn) begin
      meta     <= '0;
      sync     <= '0;
      tick_cnt <= '0;
    end else begin
      meta     <= raw_btn;
      sync     <= meta;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_cond_ch #(
      .DB_TICKS     (DB_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk_p  (clk_p),
      .resetn (resetn),
      .sync   (sync[i]),
      .tick   (tick),
      .level  (btn_level[i]),
      .press  (btn_press[i]),
      .rel    (btn_release[i]),
      .rpt    (btn_repeat[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of button channels, range 1..32.
REQ-002 SHALL have parameter TICK_DIV, default 25200: clk_p cycles per timebase tick, which is 1 ms at 25.2 MHz; minimum 2.
REQ-003 SHALL have parameter DB_TICKS, default 5: debounce length in ticks; minimum 1.
REQ-004 SHALL have parameters REPEAT_DELAY, default 400, and REPEAT_RATE, default 100: autorepeat first-delay and period in ticks; minimum 1 each.
REQ-005 SHALL have port clk_p, input, width 1: the single clock (pixel clock domain).
REQ-006 SHALL have port resetn, input, width 1: reset, synchronous and active-low.
REQ-007 SHALL have port raw_btn, input, width NUM_CH: asynchronous active-high buttons (pad, board switches).
REQ-008 SHALL have port btn_level, output, width NUM_CH: debounced level.
REQ-009 SHALL have ports btn_press and btn_release, output, width NUM_CH each: one-cycle edge pulses.
REQ-010 SHALL have port btn_repeat, output, width NUM_CH: one-cycle autorepeat pulses.
REQ-011 SHALL have port any_press, output, width 1: OR of btn_press.
REQ-012 SHALL have port tick, output, width 1: timebase strobe.

Function
REQ-013 SHALL synchronise each raw_btn bit through two flip-flops; only the synchronised value (sync) is used downstream.
REQ-014 SHALL run one free-running tick counter over 0..TICK_DIV-1; tick is high for exactly one cycle when the counter equals TICK_DIV-1, then the counter wraps to 0.
REQ-015 SHALL run, per channel, an FSM with states RELEASED, PRESS_PEND, PRESSED and RELEASE_PEND, plus a debounce counter db_cnt.
REQ-016 RELEASED: when sync=1, go to PRESS_PEND with db_cnt=0.
REQ-017 PRESS_PEND: when sync=0, return to RELEASED with no pulse; otherwise db_cnt increments on each tick, and when it reaches DB_TICKS go to PRESSED.
REQ-018 RELEASE_PEND: when sync=1, return to PRESSED with no pulse and without restarting repeat timing; otherwise db_cnt increments on each tick, and when it reaches DB_TICKS go to RELEASED.
REQ-019 PRESSED: when sync=0, go to RELEASE_PEND with db_cnt=0.
REQ-020 Sync reversal on the same cycle as a tick SHALL take priority over the tick: the state reverts and the count is discarded.
REQ-021 btn_level SHALL be 1 in PRESSED and RELEASE_PEND and 0 otherwise, registered.
REQ-022 btn_press SHALL pulse for one cycle on the cycle after the PRESS_PEND to PRESSED transition; btn_release SHALL pulse likewise on RELEASE_PEND to RELEASED.
REQ-023 Press latency from a raw_btn edge SHALL lie between (DB_TICKS-1)*TICK_DIV+3 and DB_TICKS*TICK_DIV+3 cycles.
REQ-024 Channels SHALL be fully independent; simultaneous events on multiple channels SHALL each produce their own pulses on the same cycle.
REQ-025 SHALL hold a repeat counter rep_cnt per channel, cleared on entry to PRESSED from PRESS_PEND.
REQ-026 rep_cnt SHALL increment on tick while in PRESSED or RELEASE_PEND.
REQ-027 btn_repeat SHALL pulse when rep_cnt reaches REPEAT_DELAY, and then every REPEAT_RATE ticks after that.
REQ-028 rep_cnt SHALL saturate and never wrap into a false pulse.
REQ-029 btn_repeat SHALL never coincide with btn_press on the same channel.
REQ-030 Counter widths SHALL be derived from the parameters, with no overflow at the maximum parameter values.

Reset
REQ-031 While resetn=0 at a clk_p edge: sync flip-flops, tick counter, db_cnt and rep_cnt SHALL be 0, every FSM SHALL be RELEASED, and all outputs SHALL be 0.
REQ-032 A button held through reset deassertion SHALL be re-debounced and produce btn_press with no preceding btn_release.
REQ-033 Reset asserted mid-press SHALL emit no btn_release.

Configuration
REQ-034 With macro INPUT_COND_AUTOREPEAT_EN defined, rep_cnt and btn_repeat SHALL behave per REQ-025..REQ-029.
REQ-035 Without INPUT_COND_AUTOREPEAT_EN, rep_cnt SHALL not be built, btn_repeat SHALL be constant 0, and REPEAT_DELAY and REPEAT_RATE SHALL be ignored.

Structure
REQ-036 Package input_cond_pkg SHALL hold the four-state FSM enum and the default parameter constants.
REQ-037 Per-channel logic (FSM, db_cnt, rep_cnt) SHALL be sub-module input_cond_ch, instantiated NUM_CH times.
REQ-038 The synchronisers, the tick generator and any_press SHALL stay in the top module.

Verification
REQ-039 Clean press: with TICK_DIV=4, DB_TICKS=3, raw_btn[0] going 0 to 1 and held -> one btn_press[0] pulse 11..15 cycles later, and btn_level[0]=1 from that cycle on.
REQ-040 Bounce: toggle raw_btn[2] every 3 cycles for 40 cycles, then hold 0 -> no btn_press and no btn_release on channel 2.
REQ-041 Autorepeat with macro defined, using REQ-039 parameters plus REPEAT_DELAY=5 and REPEAT_RATE=2: hold raw_btn[1] -> btn_repeat[1] at 5 ticks after press and every 2 ticks after that; release -> one btn_release and no further repeats.
REQ-042 Simultaneous events: raw_btn=8'hFF asserted on a single cycle -> all 8 btn_press bits high on the same cycle and any_press=1 for exactly one cycle.
REQ-043 Reset mid-press: resetn=0 for 2 cycles while a channel is PRESSED and the button stays held -> outputs 0 during reset, no btn_release, then btn_press again after the debounce time.
REQ-044 Macro undefined: run the REQ-041 stimulus -> btn_repeat stays 0 throughout, while btn_press and btn_release are unchanged.
